spi_reg_master: RTL

Host-side SPI controller that issues frames in the register-interface protocol served by the on-chip SPI register slave: command byte, then zero or more REG_W-bit data words, MSB first, SPI mode 0. Accepts read, write and fast-command requests on a valid/ready port, generates nss/sclk/mosi, and returns the captured status byte and read words. Used in the test harness and in multi-chip builds that drive the slave from another design on a different clock.

---
 rtl/spi_reg_master.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_master.sv
// SPI mode-0 host for the register-slave protocol: command byte, then REG_W-bit data words, MSB first.
// One frame per accepted request (cmd_valid & cmd_ready); requests arriving while busy are dropped.
module spi_reg_master #(
  parameter int REG_W = 8,
  parameter int LEN_W = 4,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [5:0]       cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [REG_W-1:0] wr_data,
  output logic             wr_taken,
  output logic [REG_W-1:0] rd_data,
  output logic             rd_valid,
  output logic [7:0]       status,
  output logic             status_valid,
  output logic             busy,
  output logic             done,
  output logic             nss,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso
);
  localparam int DIV_W = $clog2(DIV);
  localparam int BIT_W = $clog2(REG_W);
  localparam logic [1:0] OP_WR   = 2'b10;
  localparam logic [1:0] OP_FAST = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_TRAIL, S_GUARD} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [LEN_W:0]     word_q, word_d;
  logic               cmd_ph_q, cmd_ph_d;
  logic [1:0]         op_q, op_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [REG_W-1:0]   tx_q, tx_d;
  logic [REG_W-1:0]   rx_q, rx_d;
  logic               sclk_q, sclk_d;
  logic               nss_q, nss_d;
  logic [REG_W-1:0]   rd_data_q, rd_data_d;
  logic [7:0]         status_q, status_d;
  logic               rd_valid_q, rd_valid_d;
  logic               status_valid_q, status_valid_d;
  logic               wr_taken_q, wr_taken_d;
  logic               done_q, done_d;

  logic               div_end;
  logic               unit_end;
  logic               last_unit;
  logic [REG_W-1:0]   rx_next;

  always_comb begin
    state_d        = state_q;
    div_d          = div_q;
    bit_d          = bit_q;
    word_d         = word_q;
    cmd_ph_d       = cmd_ph_q;
    op_d           = op_q;
    len_d          = len_q;
    tx_d           = tx_q;
    rx_d           = rx_q;
    sclk_d         = sclk_q;
    nss_d          = nss_q;
    rd_data_d      = rd_data_q;
    status_d       = status_q;
    rd_valid_d     = 1'b0;
    status_valid_d = 1'b0;
    wr_taken_d     = 1'b0;
    done_d         = 1'b0;

    div_end   = (div_q == DIV_W'(DIV - 1));
    unit_end  = cmd_ph_q ? (bit_q == BIT_W'(7)) : (bit_q == BIT_W'(REG_W - 1));
    // word_q is one bit wider than len_q so an all-ones length never wraps
    last_unit = cmd_ph_q ? (op_q == OP_FAST) : (word_q == {1'b0, len_q});
    rx_next   = {rx_q[REG_W-2:0], miso};

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d     = cmd_op;
          len_d    = cmd_len;
          tx_d     = REG_W'({cmd_op, cmd_addr}) << (REG_W - 8);
          div_d    = '0;
          bit_d    = '0;
          word_d   = '0;
          cmd_ph_d = 1'b1;
          nss_d    = 1'b0;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        div_d = div_q + 1'b1;
        if (div_end) begin
          div_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        div_d = div_q + 1'b1;
        if (div_end) begin
          div_d  = '0;
          sclk_d = !sclk_q;
          if (!sclk_q) begin
            rx_d = rx_next;
            if (unit_end && cmd_ph_q) begin
              status_d       = rx_next[7:0];
              status_valid_d = 1'b1;
            end else if (unit_end && !op_q[1]) begin
              rd_data_d  = rx_next;
              rd_valid_d = 1'b1;
            end
          end else begin
            // falling edge: shift out next bit; zeros fill in behind so mosi idles low
            tx_d  = tx_q << 1;
            bit_d = bit_q + 1'b1;
            if (unit_end) begin
              bit_d    = '0;
              cmd_ph_d = 1'b0;
              if (!cmd_ph_q) word_d = word_q + 1'b1;
              if (last_unit) begin
                state_d = S_TRAIL;
              end else if (op_q == OP_WR) begin
                tx_d       = wr_data;
                wr_taken_d = 1'b1;
              end
            end
          end
        end
      end
      S_TRAIL: begin
        div_d = div_q + 1'b1;
        if (div_end) begin
          div_d   = '0;
          nss_d   = 1'b1;
          state_d = S_GUARD;
        end
      end
      S_GUARD: begin
        div_d = div_q + 1'b1;
        if (div_end) begin
          div_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q        <= S_IDLE;
      div_q          <= '0;
      bit_q          <= '0;
      word_q         <= '0;
      cmd_ph_q       <= 1'b0;
      op_q           <= '0;
      len_q          <= '0;
      tx_q           <= '0;
      rx_q           <= '0;
      sclk_q         <= 1'b0;
      nss_q          <= 1'b1;
      rd_data_q      <= '0;
      status_q       <= '0;
      rd_valid_q     <= 1'b0;
      status_valid_q <= 1'b0;
      wr_taken_q     <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      div_q          <= div_d;
      bit_q          <= bit_d;
      word_q         <= word_d;
      cmd_ph_q       <= cmd_ph_d;
      op_q           <= op_d;
      len_q          <= len_d;
      tx_q           <= tx_d;
      rx_q           <= rx_d;
      sclk_q         <= sclk_d;
      nss_q          <= nss_d;
      rd_data_q      <= rd_data_d;
      status_q       <= status_d;
      rd_valid_q     <= rd_valid_d;
      status_valid_q <= status_valid_d;
      wr_taken_q     <= wr_taken_d;
      done_q         <= done_d;
    end
  end

  assign cmd_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign nss          = nss_q;
  assign sclk         = sclk_q;
  assign mosi         = tx_q[REG_W-1];
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign status       = status_q;
  assign status_valid = status_valid_q;
  assign wr_taken     = wr_taken_q;
  assign done         = done_q;

endmodule
